// File: rtl/candidate_selector.sv
// Scans count_bus after a query and reports the best and second-best vote counts.
// Results are registered on entry to DONE and held until the next DONE.
module candidate_selector #(
    parameter int MAX_WINDOWS_IN_REFERENCE = 1024,
    parameter int LOG2_MAX_WINDOWS         = 10,
    parameter int COUNT_WIDTH              = 32
) (
    input  logic                        clk,
    input  logic                        reset_candidate_selector,
    input  logic                        start,
    input  logic [LOG2_MAX_WINDOWS:0]   num_windows,
    input  logic [COUNT_WIDTH-1:0]      min_count,
    input  logic [COUNT_WIDTH-1:0]      count_bus [0:MAX_WINDOWS_IN_REFERENCE-1],
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 best_window_id,
    output logic [COUNT_WIDTH-1:0]      best_count,
    output logic [COUNT_WIDTH-1:0]      second_count,
    output logic                        found
);

    localparam int NW = LOG2_MAX_WINDOWS + 1;
    localparam logic [NW-1:0] MAX_N = NW'(MAX_WINDOWS_IN_REFERENCE);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                      state;
    state_t                      state_next;
    logic [NW-1:0]               n_lat;
    logic [NW-1:0]               idx;
    logic [NW-1:0]               n_clamped;
    logic [COUNT_WIDTH-1:0]      min_lat;
    logic [COUNT_WIDTH-1:0]      best;
    logic [COUNT_WIDTH-1:0]      second;
    logic [COUNT_WIDTH-1:0]      cur;
    logic [LOG2_MAX_WINDOWS-1:0] best_id;
    logic                        scan_last;

    assign n_clamped = (num_windows > MAX_N) ? MAX_N : num_windows;
    assign cur       = count_bus[idx[LOG2_MAX_WINDOWS-1:0]];
    // The cycle with idx == N processes nothing; it is the hand-off into DONE
    // (and the one latency cycle an empty scan still spends in SCAN).
    assign scan_last = (idx == n_lat);

    always_ff @(posedge clk) begin
        if (reset_candidate_selector) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (scan_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_candidate_selector) begin
            n_lat          <= '0;
            min_lat        <= '0;
            idx            <= '0;
            best           <= '0;
            second         <= '0;
            best_id        <= '0;
            best_window_id <= '0;
            best_count     <= '0;
            second_count   <= '0;
            found          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat   <= n_clamped;
                        min_lat <= min_count;
                        idx     <= '0;
                        best    <= '0;
                        second  <= '0;
                        best_id <= '0;
                    end
                end
                SCAN: begin
                    if (!scan_last) begin
                        idx <= idx + 1'b1;
                        // Strict compare keeps the lowest index among equal maxima.
                        if (cur > best) begin
                            second  <= best;
                            best    <= cur;
                            best_id <= idx[LOG2_MAX_WINDOWS-1:0];
                        end else if (cur > second) begin
                            second <= cur;
                        end
                    end else begin
                        best_window_id <= 32'(best_id);
                        best_count     <= best;
                        second_count   <= second;
                        found          <= (n_lat != '0) && (best >= min_lat);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_candidate_selector.sv
// Directed bench for candidate_selector: hand-computed vectors checked with
// immediate assertions, stimulus as one linear sequence.
module tb_candidate_selector;

    logic        clk;
    logic        reset_candidate_selector;
    logic        start;
    logic [10:0] num_windows;
    logic [31:0] min_count;
    logic [31:0] count_bus [0:1023];
    logic        busy;
    logic        done;
    logic [31:0] best_window_id;
    logic [31:0] best_count;
    logic [31:0] second_count;
    logic        found;

    int vectors     = 0;
    int miscompares = 0;

    candidate_selector dut (
        .clk                      (clk),
        .reset_candidate_selector (reset_candidate_selector),
        .start                    (start),
        .num_windows              (num_windows),
        .min_count                (min_count),
        .count_bus                (count_bus),
        .busy                     (busy),
        .done                     (done),
        .best_window_id           (best_window_id),
        .best_count               (best_count),
        .second_count             (second_count),
        .found                    (found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_bus(input logic [31:0] v);
        for (int i = 0; i < 1024; i++) count_bus[i] = v;
    endtask

    // Drives start for one cycle from a negedge; returns at the negedge after E0.
    task automatic apply_stimulus(input int n, input logic [31:0] minc);
        start       = 1'b1;
        num_windows = 11'(n);
        min_count   = minc;
        @(negedge clk);
        start       = 1'b0;
        num_windows = 11'(3);
        min_count   = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input int budget, output int latency);
        latency = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                latency = k;
                break;
            end
        end
    endtask

    task automatic check_results(input string tag, input logic [31:0] id, input logic [31:0] bc,
                                 input logic [31:0] sc, input logic f);
        check_output({tag, ".id"},     64'(best_window_id), 64'(id));
        check_output({tag, ".best"},   64'(best_count),     64'(bc));
        check_output({tag, ".second"}, 64'(second_count),   64'(sc));
        check_output({tag, ".found"},  64'(found),          64'(f));
    endtask

    int lat;
    int pulses;
    int first_lat;

    initial begin
        reset_candidate_selector = 1'b1;
        start       = 1'b0;
        num_windows = '0;
        min_count   = '0;
        clear_bus(32'd0);
        repeat (2) @(negedge clk);
        check_output("reset.busy", 64'(busy), 64'd0);
        check_output("reset.done", 64'(done), 64'd0);
        check_results("reset", 32'd0, 32'd0, 32'd0, 1'b0);
        reset_candidate_selector = 1'b0;
        @(negedge clk);

        // Single peak
        clear_bus(32'd0);
        count_bus[0] = 0; count_bus[1] = 3; count_bus[2] = 1; count_bus[3] = 9;
        count_bus[4] = 2; count_bus[5] = 0; count_bus[6] = 4; count_bus[7] = 1;
        apply_stimulus(8, 32'd5);
        check_output("peak.busy_scan", 64'(busy), 64'd1);
        wait_done(50, lat);
        check_output("peak.latency", 64'(lat), 64'd9);
        check_output("peak.busy_done", 64'(busy), 64'd1);
        check_results("peak", 32'd3, 32'd9, 32'd4, 1'b1);
        @(negedge clk);
        check_output("peak.done_pulse", 64'(done), 64'd0);
        check_output("peak.busy_idle", 64'(busy), 64'd0);
        check_results("peak.hold", 32'd3, 32'd9, 32'd4, 1'b1);

        // Tie and threshold
        clear_bus(32'd0);
        count_bus[0] = 7; count_bus[1] = 2; count_bus[2] = 7; count_bus[3] = 5;
        apply_stimulus(4, 32'd8);
        wait_done(50, lat);
        check_output("tie.latency", 64'(lat), 64'd5);
        check_results("tie", 32'd0, 32'd7, 32'd7, 1'b0);
        @(negedge clk);

        // Empty scan, min_count 0 still gives found=0
        clear_bus(32'd9);
        apply_stimulus(0, 32'd0);
        wait_done(50, lat);
        check_output("empty.latency", 64'(lat), 64'd1);
        check_results("empty", 32'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);

        // Clamp of an oversized window count
        clear_bus(32'd1);
        count_bus[1023] = 50;
        apply_stimulus(2000, 32'd10);
        wait_done(3000, lat);
        check_output("clamp.latency", 64'(lat), 64'd1025);
        check_results("clamp", 32'd1023, 32'd50, 32'd1, 1'b1);
        @(negedge clk);

        // Start while busy is ignored
        clear_bus(32'd0);
        for (int i = 0; i < 16; i++) count_bus[i] = 32'(i);
        apply_stimulus(16, 32'd0);
        pulses    = 0;
        first_lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                start       = 1'b1;
                num_windows = 11'd2;
                min_count   = 32'd100;
            end
            if (k == 6) start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                if (first_lat < 0) begin
                    first_lat = k;
                    check_results("busystart", 32'd15, 32'd15, 32'd14, 1'b1);
                end
            end
        end
        check_output("busystart.pulses", 64'(pulses), 64'd1);
        check_output("busystart.latency", 64'(first_lat), 64'd17);

        // Reset in the middle of a scan
        clear_bus(32'd2);
        count_bus[10] = 77;
        apply_stimulus(100, 32'd0);
        repeat (39) @(negedge clk);
        reset_candidate_selector = 1'b1;
        @(negedge clk);
        reset_candidate_selector = 1'b0;
        check_output("midreset.busy", 64'(busy), 64'd0);
        check_output("midreset.done", 64'(done), 64'd0);
        check_results("midreset", 32'd0, 32'd0, 32'd0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check_output("midreset.no_done", 64'(pulses), 64'd0);
        clear_bus(32'd0);
        count_bus[0] = 1; count_bus[1] = 2; count_bus[2] = 3;
        apply_stimulus(3, 32'd0);
        wait_done(50, lat);
        check_output("after_reset.latency", 64'(lat), 64'd4);
        check_results("after_reset", 32'd2, 32'd3, 32'd2, 1'b1);

        // Back-to-back scans; first one also exercises unsigned compare
        @(negedge clk);
        clear_bus(32'd0);
        count_bus[0] = 32'h8000_0000; count_bus[1] = 9;
        apply_stimulus(2, 32'd1);
        wait_done(50, lat);
        check_output("b2b1.latency", 64'(lat), 64'd3);
        check_results("b2b1", 32'd0, 32'h8000_0000, 32'd9, 1'b1);
        @(negedge clk);
        check_output("b2b.idle", 64'(busy), 64'd0);
        count_bus[0] = 4; count_bus[1] = 0; count_bus[2] = 6;
        apply_stimulus(3, 32'd7);
        check_output("b2b2.accepted", 64'(busy), 64'd1);
        wait_done(50, lat);
        check_output("b2b2.latency", 64'(lat), 64'd4);
        check_results("b2b2", 32'd2, 32'd6, 32'd4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
